// File: rtl/delay_arb_pkg.sv
// Shared types and defaults for the 2-second delay arbiter.
package delay_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int LEN_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/delay_arbiter_if.sv
// Requester/Counter-facing signals of the delay arbiter; slave is the arbiter side.
interface delay_arbiter_if
  import delay_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int IDX_W = $clog2(N_REQ)
);

  logic [N_REQ-1:0]       i_Req;
  logic [N_REQ*LEN_W-1:0] i_Len;
  logic                   i_Abort;
  logic                   i_TwoSec;
  logic                   o_ActCounter;
  logic                   o_RstCounter;
  logic [N_REQ-1:0]       o_Grant;
  logic [IDX_W-1:0]       o_Owner;
  logic [N_REQ-1:0]       o_Done;
  logic                   o_Busy;

  modport master (
    output i_Req, i_Len, i_Abort, i_TwoSec,
    input  o_ActCounter, o_RstCounter, o_Grant, o_Owner, o_Done, o_Busy
  );

  modport slave (
    input  i_Req, i_Len, i_Abort, i_TwoSec,
    output o_ActCounter, o_RstCounter, o_Grant, o_Owner, o_Done, o_Busy
  );

endinterface

// File: rtl/delay_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit after last_owner, wrapping.
module rr_picker
  import delay_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int               k;
  logic [IDX_W-1:0] cand;

  // Walk farthest-first so the nearest hit after last_owner overwrites the rest.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = int'(last_owner) + i;
      if (k >= N_REQ) k = k - N_REQ;
      cand = IDX_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin owner of the shared 2-second Counter; chains len+1 periods per grant
// and returns a one-cycle done pulse to the owner.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic           clk_2K,
  input  logic           i_Reset,
  delay_arbiter_if.slave bus
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] last_owner, last_nxt;
  logic [LEN_W-1:0] remaining, rem_nxt;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] owner_oh;
  logic             keep_going;
  logic [LEN_W-1:0] len_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_len
    assign len_arr[g] = bus.i_Len[g*LEN_W +: LEN_W];
  end

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req        (bus.i_Req),
    .last_owner (last_owner),
    .valid      (pick_vld),
    .idx        (pick_idx)
  );

  assign owner_oh   = N_REQ'(1) << owner;
  assign keep_going = !bus.i_Abort && bus.i_Req[owner];

  always_ff @(posedge clk_2K or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      remaining  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      remaining  <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    owner_nxt        = owner;
    last_nxt         = last_owner;
    rem_nxt          = remaining;
    bus.o_ActCounter = 1'b0;
    bus.o_RstCounter = 1'b1;
    bus.o_Grant      = '0;
    bus.o_Done       = '0;
    bus.o_Busy       = 1'b1;
    bus.o_Owner      = owner;
    case (state)
      IDLE: begin
        bus.o_Busy = 1'b0;
        if (pick_vld) begin
          owner_nxt = pick_idx;
          rem_nxt   = len_arr[pick_idx];
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        bus.o_Grant = owner_oh;
        if (!keep_going) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.o_Grant      = owner_oh;
        bus.o_ActCounter = 1'b1;
        bus.o_RstCounter = 1'b0;
        // Abort/drop outranks a same-cycle expiry: the owner gets no done pulse.
        if (!keep_going) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (bus.i_TwoSec) begin
          if (remaining == '0) begin
            state_nxt = DONE;
          end else begin
            rem_nxt   = remaining - 1'b1;
            state_nxt = CLEAR;
          end
        end
      end
      DONE: begin
        bus.o_Grant = owner_oh;
        bus.o_Done  = owner_oh;
        last_nxt    = owner;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
